feature_scan_ctrl: RTL and testbench
====================================

Name: feature_scan_ctrl

Overview:
- Upstream sequencer for the feature read stage (FeatureProcessor).
- Walks every output pixel of one conv layer; drives that stage's iReadCenterAddr, nCe, iKernelSize, inHW and iDepth.
- Emits per-read valid/first/last markers aligned to the read stage's registered data output, so the downstream MAC knows window boundaries.
- Supports 1x1 and 3x3 kernels, stride 1 or 2.

Parameters:
P_ADDR_W, 10, feature address width; all address arithmetic is modulo 2^P_ADDR_W
P_PIX_W, 12, width of output-pixel counter

Ports:
clk  input  1  clock
Rst  input  1  synchronous active-high reset
iStart  input  1  start-of-layer pulse; sampled only in IDLE
iKernelSize  input  2  3 = 3x3, any other value = 1x1; latched at start
inHW  input  6  input feature height = width; latched at start
iDepth  input  4  depth in 64-lane words; latched at start
iStride  input  1  0 = stride 1, 1 = stride 2; latched at start
oReadCenterAddr  output  P_ADDR_W  center address of current window
onCe  output  1  active-low read enable to read stage
oKernelSize  output  2  latched kernel size
onHW  output  6  latched inHW
oDepth  output  4  latched iDepth
oDataValid  output  1  read-stage data output valid this cycle
oWinFirst  output  1  with oDataValid: first word of a window
oWinLast  output  1  with oDataValid: last word of a window
oPixIdx  output  P_PIX_W  index of window whose data is currently presented
oBusy  output  1  high from cycle after accepted iStart through DONE
oDone  output  1  one-cycle pulse, layer complete

Behaviour:
- Reset, checked before all else, every cycle, including mid-layer: state IDLE; onCe=1; oReadCenterAddr=0; all other outputs 0.
- Configuration is latched at the accepted iStart and does not change until IDLE.
- Window length W:
  - 3x3: 9*iDepth cycles.
  - 1x1: iDepth cycles.
  - Computed at start.
- Output grid (row, col):
  - Stride 1: 0..inHW-1.
  - Stride 2: 0, 2, 4, ... < inHW.
  - Raster order, col fastest.
- oReadCenterAddr = (row*inHW + col)*iDepth, truncated to P_ADDR_W. Held constant for a whole window.
- FSM states:
  - IDLE:
    - iStart=1 with iDepth==0 or inHW==0: go DONE; no reads issued.
    - iStart=1 otherwise: latch config, row=col=0, window counter=0, go READ.
  - READ:
    - onCe=0.
    - Counter increments each cycle 0..W-1.
    - At W-1: go GAP if more pixels remain, else DONE.
  - GAP:
    - Exactly one cycle, onCe=1. This resets the read stage's internal depth/tap counters.
    - Advance col by stride; on passing inHW-1, col=0 and row += stride.
    - Update oReadCenterAddr; go READ.
  - DONE: oDone=1 for one cycle; onCe=1; go IDLE.
- oBusy = 1 in READ, GAP and DONE.
- iStart outside IDLE is ignored.
- Marker pipeline (one register stage, matching the read stage's one-cycle registered read latency):
  - oDataValid(t) = READ at t-1.
  - oWinFirst(t) = counter==0 at t-1.
  - oWinLast(t) = counter==W-1 at t-1.
  - oPixIdx(t) = pixel index at t-1.
  - Markers are 0 whenever oDataValid=0.
  - oDataValid is therefore 1 in every GAP cycle and in the DONE cycle (final word).
- oPixIdx is 0-based and increments by 1 per window.
- For inHW=1 with 3x3, the single window still runs 9*iDepth cycles; padding is the read stage's job.
- Throughput: one window per W+1 cycles.
- Layer latency from accepted iStart: N*W + (N-1) + 1 cycles to oDone, where N = number of output pixels.

Test Plan:
1. Rst, then inHW=4, iDepth=2, k=3, stride1, iStart at cycle 0:
   - READ from cycle 1; 16 windows of 18 onCe-low cycles separated by single onCe-high cycles.
   - oDone at cycle 304.
   - oReadCenterAddr sequence 0, 2, 4, ..., 30.
2. inHW=4, iDepth=1, k=1, stride2:
   - 4 windows of 1 cycle; centers 0, 2, 8, 10.
   - oWinFirst=oWinLast=1 on each valid word.
   - oPixIdx 0..3.
3. iDepth=0 with iStart: oDone exactly 1 cycle later, onCe never low, oDataValid never high.
4. Assert Rst during window 5 of scenario 1:
   - Next cycle onCe=1, all outputs 0, state IDLE.
   - A fresh iStart restarts at center 0.
5. Pulse iStart while busy; change inputs mid-layer:
   - No effect.
   - Window count and addresses match the config latched at start.
6. inHW=32, iDepth=2, k=3, stride1: center for pixel 511 = 1022; no wrap; oDone after 512*18+511+1 cycles.

Source files
------------

// File: rtl/feature_scan_ctrl.sv
// Sequencer for the feature read stage: walks every output pixel of one conv layer
// and emits window markers aligned to the read stage's one-cycle registered output.
//
// state | meaning
// IDLE  | waiting for iStart, config not yet latched
// READ  | onCe low, one window of winLen reads at a fixed center address
// GAP   | one onCe-high cycle between windows, advance to next pixel
// DONE  | one-cycle oDone pulse, then back to IDLE
module feature_scan_ctrl #(
  parameter int P_ADDR_W = 10,
  parameter int P_PIX_W  = 12
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                iStart,
  input  logic [1:0]          iKernelSize,
  input  logic [5:0]          inHW,
  input  logic [3:0]          iDepth,
  input  logic                iStride,
  output logic [P_ADDR_W-1:0] oReadCenterAddr,
  output logic                onCe,
  output logic [1:0]          oKernelSize,
  output logic [5:0]          onHW,
  output logic [3:0]          oDepth,
  output logic                oDataValid,
  output logic                oWinFirst,
  output logic                oWinLast,
  output logic [P_PIX_W-1:0]  oPixIdx,
  output logic                oBusy,
  output logic                oDone
);

  typedef enum logic [1:0] {IDLE, READ, GAP, DONE} state_t;

  state_t state, nextState;

  logic [1:0]          kSizeReg;
  logic [5:0]          hwReg;
  logic [3:0]          depthReg;
  logic                strideReg;
  logic [7:0]          winLen;
  logic [7:0]          winCnt;
  logic [5:0]          row, col, nextRow, nextCol;
  logic [6:0]          stepInc, colStep;
  logic [P_PIX_W-1:0]  pixIdx;
  logic [P_ADDR_W-1:0] addrReg, nextAddr;
  logic                cfgZero, winEnd, colWrap, lastPix;
  logic                validReg, firstReg, lastReg;
  logic [P_PIX_W-1:0]  pixOutReg;

  assign cfgZero = (iDepth == 4'd0) || (inHW == 6'd0);
  assign winEnd  = (winCnt == winLen - 8'd1);
  assign stepInc = strideReg ? 7'd2 : 7'd1;
  assign colStep = {1'b0, col} + stepInc;
  assign colWrap = (colStep >= {1'b0, hwReg});
  assign lastPix = colWrap && (({1'b0, row} + stepInc) >= {1'b0, hwReg});

  always_comb begin
    nextCol = colStep[5:0];
    nextRow = row;
    if (colWrap) begin
      nextCol = 6'd0;
      nextRow = row + stepInc[5:0];
    end
  end

  // Address arithmetic wraps at 2^P_ADDR_W by truncation.
  assign nextAddr = P_ADDR_W'((32'(nextRow) * 32'(hwReg) + 32'(nextCol)) * 32'(depthReg));

  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (iStart) nextState = cfgZero ? DONE : READ;
      READ: if (winEnd) nextState = lastPix ? DONE : GAP;
      GAP:  nextState = READ;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      kSizeReg  <= '0;
      hwReg     <= '0;
      depthReg  <= '0;
      strideReg <= 1'b0;
      winLen    <= '0;
      winCnt    <= '0;
      row       <= '0;
      col       <= '0;
      pixIdx    <= '0;
      addrReg   <= '0;
      validReg  <= 1'b0;
      firstReg  <= 1'b0;
      lastReg   <= 1'b0;
      pixOutReg <= '0;
    end else begin
      case (state)
        IDLE: if (iStart) begin
          kSizeReg  <= iKernelSize;
          hwReg     <= inHW;
          depthReg  <= iDepth;
          strideReg <= iStride;
          winLen    <= (iKernelSize == 2'd3) ? 8'(iDepth) * 8'd9 : 8'(iDepth);
          winCnt    <= '0;
          row       <= '0;
          col       <= '0;
          pixIdx    <= '0;
          addrReg   <= '0;
        end
        READ: winCnt <= winEnd ? 8'd0 : winCnt + 8'd1;
        GAP: begin
          col     <= nextCol;
          row     <= nextRow;
          addrReg <= nextAddr;
          pixIdx  <= pixIdx + 1'b1;
        end
        default: ;
      endcase
      // Markers trail the read by one cycle to line up with the read stage's data.
      validReg  <= (state == READ);
      firstReg  <= (state == READ) && (winCnt == 8'd0);
      lastReg   <= (state == READ) && winEnd;
      pixOutReg <= (state == READ) ? pixIdx : '0;
    end
  end

  assign oReadCenterAddr = addrReg;
  assign onCe            = (state != READ);
  assign oKernelSize     = kSizeReg;
  assign onHW            = hwReg;
  assign oDepth          = depthReg;
  assign oDataValid      = validReg;
  assign oWinFirst       = firstReg;
  assign oWinLast        = lastReg;
  assign oPixIdx         = pixOutReg;
  assign oBusy           = (state != IDLE);
  assign oDone           = (state == DONE);

endmodule

// File: tb/tb_feature_scan_ctrl.sv
// Bench for feature_scan_ctrl: a loop-based pixel/window model fills expectation
// queues at each start; a negedge monitor pops and compares what the DUT presents.
module tb_feature_scan_ctrl;
  localparam int AW = 10;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          Rst;
  logic          iStart;
  logic [1:0]    iKernelSize;
  logic [5:0]    inHW;
  logic [3:0]    iDepth;
  logic          iStride;
  logic [AW-1:0] oReadCenterAddr;
  logic          onCe;
  logic [1:0]    oKernelSize;
  logic [5:0]    onHW;
  logic [3:0]    oDepth;
  logic          oDataValid, oWinFirst, oWinLast;
  logic [PW-1:0] oPixIdx;
  logic          oBusy, oDone;

  feature_scan_ctrl #(.P_ADDR_W(AW), .P_PIX_W(PW)) dut (
    .clk(clk), .Rst(Rst), .iStart(iStart), .iKernelSize(iKernelSize), .inHW(inHW),
    .iDepth(iDepth), .iStride(iStride), .oReadCenterAddr(oReadCenterAddr), .onCe(onCe),
    .oKernelSize(oKernelSize), .onHW(onHW), .oDepth(oDepth), .oDataValid(oDataValid),
    .oWinFirst(oWinFirst), .oWinLast(oWinLast), .oPixIdx(oPixIdx), .oBusy(oBusy),
    .oDone(oDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit first; bit last; int pix; } mark_t;

  int          passCnt = 0;
  int          totalCnt = 0;
  int          readQ[$];
  mark_t       markQ[$];
  int          expDoneCyc = 0;
  logic [11:0] expCfg = '0;
  int          doneCnt = 0;
  bit          monitorOn = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void checkReset();
    logic [39:0] v;
    v = {onCe, oReadCenterAddr, oKernelSize, onHW, oDepth, oDataValid, oWinFirst,
         oWinLast, oPixIdx, oBusy, oDone};
    check("reset_outputs", 64'(v), 64'(40'h1 << 39));
  endfunction

  mark_t m;
  int    eAddr;
  always @(negedge clk) begin
    if (monitorOn) begin
      if (!onCe) begin
        if (readQ.size() == 0) check("unexpected_read", 1, 0);
        else begin
          eAddr = readQ.pop_front();
          check("center_addr", 64'(oReadCenterAddr), 64'(eAddr));
        end
      end
      if (oDataValid) begin
        if (markQ.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          m = markQ.pop_front();
          check("win_first", 64'(oWinFirst), 64'(m.first));
          check("win_last", 64'(oWinLast), 64'(m.last));
          check("pix_idx", 64'(oPixIdx), 64'(m.pix));
        end
      end else begin
        check("markers_idle", 64'({oWinFirst, oWinLast, oPixIdx}), 0);
      end
      if (oDone) begin
        doneCnt++;
        check("done_cycle", 64'(cyc), 64'(expDoneCyc));
        check("queues_drained", 64'(readQ.size() + markQ.size()), 0);
        check("busy_in_done", 64'(oBusy), 1);
        check("latched_cfg", 64'({oKernelSize, onHW, oDepth}), 64'(expCfg));
      end
    end
  end

  task automatic runLayer(input int hw, input int d, input int k, input int s,
                          input bit disturb, input int abortAt);
    int w, n, lat, startDone, waited, step;
    w = (k == 3) ? 9 * d : d;
    step = s ? 2 : 1;
    @(negedge clk); #1;
    n = 0;
    if (d > 0 && hw > 0) begin
      for (int r = 0; r < hw; r += step)
        for (int c = 0; c < hw; c += step) begin
          for (int i = 0; i < w; i++) begin
            readQ.push_back(((r * hw + c) * d) % (1 << AW));
            markQ.push_back('{first: (i == 0), last: (i == w - 1), pix: n});
          end
          n++;
        end
    end
    lat = (n == 0) ? 1 : n * (w + 1);
    expDoneCyc = cyc + lat;
    expCfg = {2'(k), 6'(hw), 4'(d)};
    startDone = doneCnt;
    iKernelSize = 2'(k); inHW = 6'(hw); iDepth = 4'(d); iStride = 1'(s);
    iStart = 1'b1;
    waited = 0;
    while (doneCnt == startDone && waited < lat + 10) begin
      @(negedge clk); #1;
      waited++;
      if (doneCnt != startDone) break;
      if (abortAt >= 0 && waited == abortAt) begin
        monitorOn = 1'b0;
        Rst = 1'b1;
        iStart = 1'b0;
        @(negedge clk); #1;
        checkReset();
        Rst = 1'b0;
        readQ.delete();
        markQ.delete();
        monitorOn = 1'b1;
        return;
      end
      if (disturb && ($urandom % 5 == 0)) begin
        iStart = 1'b1;
        iKernelSize = 2'($urandom); inHW = 6'($urandom); iDepth = 4'($urandom);
        iStride = 1'($urandom);
      end else begin
        iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    if (doneCnt == startDone) begin
      check("done_timeout", 0, 1);
      readQ.delete();
      markQ.delete();
    end
    @(negedge clk); #1;
    check("idle_after_done", 64'({oBusy, onCe, oDone}), 64'(3'b010));
  endtask

  initial begin
    Rst = 1'b1; iStart = 1'b0; iKernelSize = '0; inHW = '0; iDepth = '0; iStride = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkReset();
    Rst = 1'b0;
    monitorOn = 1'b1;

    runLayer(4, 2, 3, 0, 1'b0, -1);
    runLayer(4, 1, 1, 1, 1'b0, -1);
    runLayer(5, 0, 3, 0, 1'b0, -1);
    runLayer(4, 2, 3, 0, 1'b0, 100);
    runLayer(4, 2, 3, 0, 1'b0, -1);
    runLayer(4, 2, 3, 0, 1'b1, -1);
    runLayer(1, 2, 3, 0, 1'b0, -1);
    runLayer(32, 2, 3, 0, 1'b0, -1);
    for (int t = 0; t < 10; t++)
      runLayer(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               1'($urandom), -1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", totalCnt);
    $fatal(1);
  end
endmodule
